// File: rtl/param_interrupt_controller.sv
// param_interrupt_controller
//   Programmable interrupt controller with rotating priority, fully nested
//   servicing and a two-pulse CPU acknowledge that returns a vector.
//
// Ports
//   clock, reset_n            rising-edge clock, async active-low reset
//   irq_in[CHANNELS]          raw interrupt requests
//   cfg_wr + cfg_*            init strobe: trigger mode, auto-EOI, auto-rotate,
//                             vector base (low IDX_W bits ignored); clears state
//   mask_wr, mask_data        interrupt mask write (1 = masked)
//   eoi_wr, eoi_specific,     end-of-interrupt command (specific level or
//   eoi_level, eoi_rotate     highest in-service bit, optional rotate)
//   inta_n                    CPU acknowledge, active-low, two pulses
//   int_out                   registered interrupt request to CPU
//   vector_valid, vector_out  vector drive during the second acknowledge pulse
//   irr_out, isr_out, imr_out request, in-service and mask registers
//
// Acknowledge FSM
//   state | meaning
//   IDLE  | waiting for first inta_n falling edge
//   ACK1  | first pulse; ISR bit latched and ack_index captured on entry
//   GAP   | between pulses
//   ACK2  | second pulse; vector driven while inta_n is low
module param_interrupt_controller #(
    parameter int CHANNELS     = 8,
    parameter int VECTOR_WIDTH = 8,
    localparam int IDX_W       = $clog2(CHANNELS)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [CHANNELS-1:0]     irq_in,
    input  logic                    cfg_wr,
    input  logic                    cfg_level,
    input  logic                    cfg_auto_eoi,
    input  logic                    cfg_auto_rotate,
    input  logic [VECTOR_WIDTH-1:0] cfg_vector_base,
    input  logic                    mask_wr,
    input  logic [CHANNELS-1:0]     mask_data,
    input  logic                    eoi_wr,
    input  logic                    eoi_specific,
    input  logic [IDX_W-1:0]        eoi_level,
    input  logic                    eoi_rotate,
    input  logic                    inta_n,
    output logic                    int_out,
    output logic                    vector_valid,
    output logic [VECTOR_WIDTH-1:0] vector_out,
    output logic [CHANNELS-1:0]     irr_out,
    output logic [CHANNELS-1:0]     isr_out,
    output logic [CHANNELS-1:0]     imr_out
);

    typedef enum logic [1:0] {S_IDLE, S_ACK1, S_GAP, S_ACK2} state_t;

    state_t                         state, state_n;
    logic [CHANNELS-1:0]            irr, isr, imr, irq_q;
    logic [CHANNELS-1:0]            irr_n, isr_n, imr_n;
    logic [IDX_W-1:0]               lowest_prio, lp_n, ack_index, ack_index_n;
    logic                           spurious_q, spurious_n;
    logic                           level_q, auto_eoi_q, auto_rotate_q;
    logic [VECTOR_WIDTH-IDX_W-1:0]  base_hi;
    logic                           inta_q, int_q, int_n;
    logic                           inta_fall, inta_rise, ack_enter, ack_exit;
    logic                           cand_found, isr_found, qualify;
    logic [IDX_W-1:0]               cand_idx, isr_idx;
    logic [IDX_W:0]                 cand_pos, isr_pos;
    logic                           unused_base_bits;

    assign unused_base_bits = ^cfg_vector_base[IDX_W-1:0];

    // Walk channels from highest priority (lp+1) downward; pos is the rank
    // (0 = highest) so two searches can be compared for nesting.
    function automatic void prio_find(input  logic [CHANNELS-1:0] vec,
                                      input  logic [IDX_W-1:0]    lp,
                                      output logic                found,
                                      output logic [IDX_W-1:0]    idx,
                                      output logic [IDX_W:0]      pos);
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            int               c;
            logic [IDX_W-1:0] ci;
            c = int'(lp) + 1 + k;
            if (c >= CHANNELS) c = c - CHANNELS;
            ci = IDX_W'(c);
            if (!found && vec[ci]) begin
                found = 1'b1;
                idx   = ci;
                pos   = (IDX_W+1)'(k);
            end
        end
    endfunction

    assign inta_fall = inta_q & ~inta_n;
    assign inta_rise = ~inta_q & inta_n;

    always_comb begin
        prio_find(irr & ~imr, lowest_prio, cand_found, cand_idx, cand_pos);
        prio_find(isr, lowest_prio, isr_found, isr_idx, isr_pos);
        qualify = cand_found && (!isr_found || (cand_pos < isr_pos));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ack_enter = 1'b0;
        ack_exit  = 1'b0;
        case (state)
            S_IDLE: if (inta_fall) begin state_n = S_ACK1; ack_enter = 1'b1; end
            S_ACK1: if (inta_rise) state_n = S_GAP;
            S_GAP:  if (inta_fall) state_n = S_ACK2;
            S_ACK2: if (inta_rise) begin state_n = S_IDLE; ack_exit = 1'b1; end
            default: state_n = S_IDLE;
        endcase
        if (cfg_wr) begin
            state_n   = S_IDLE;
            ack_enter = 1'b0;
            ack_exit  = 1'b0;
        end
    end

    // Register updates. Order matters: EOI/auto-EOI clears are applied
    // before the ACK1 latch so a same-cycle set of the same bit wins.
    always_comb begin
        irr_n       = level_q ? irq_in : (irr | (irq_in & ~irq_q));
        isr_n       = isr;
        imr_n       = mask_wr ? mask_data : imr;
        lp_n        = lowest_prio;
        ack_index_n = ack_index;
        spurious_n  = spurious_q;
        int_n       = qualify && !ack_enter;

        if (eoi_wr) begin
            if (eoi_specific) begin
                if (int'(eoi_level) < CHANNELS) begin
                    isr_n[eoi_level] = 1'b0;
                    if (eoi_rotate) lp_n = eoi_level;
                end
            end else if (isr_found) begin
                isr_n[isr_idx] = 1'b0;
                if (eoi_rotate) lp_n = isr_idx;
            end
        end

        if (ack_exit && !spurious_q) begin
            if (auto_eoi_q)    isr_n[ack_index] = 1'b0;
            if (auto_rotate_q) lp_n = ack_index;
        end

        if (ack_enter) begin
            spurious_n  = !cand_found;
            ack_index_n = cand_found ? cand_idx : IDX_W'(CHANNELS-1);
            if (cand_found) begin
                isr_n[cand_idx] = 1'b1;
                irr_n[cand_idx] = 1'b0;
            end
        end

        if (cfg_wr) begin
            irr_n = '0;
            isr_n = '0;
            imr_n = '0;
            lp_n  = IDX_W'(CHANNELS-1);
            int_n = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irr           <= '0;
            isr           <= '0;
            imr           <= '0;
            irq_q         <= '0;
            lowest_prio   <= IDX_W'(CHANNELS-1);
            ack_index     <= '0;
            spurious_q    <= 1'b0;
            level_q       <= 1'b0;
            auto_eoi_q    <= 1'b0;
            auto_rotate_q <= 1'b0;
            base_hi       <= '0;
            inta_q        <= 1'b1;
            int_q         <= 1'b0;
        end else begin
            irr         <= irr_n;
            isr         <= isr_n;
            imr         <= imr_n;
            irq_q       <= irq_in;
            lowest_prio <= lp_n;
            ack_index   <= ack_index_n;
            spurious_q  <= spurious_n;
            inta_q      <= inta_n;
            int_q       <= int_n;
            if (cfg_wr) begin
                level_q       <= cfg_level;
                auto_eoi_q    <= cfg_auto_eoi;
                auto_rotate_q <= cfg_auto_rotate;
                base_hi       <= cfg_vector_base[VECTOR_WIDTH-1:IDX_W];
            end
        end
    end

    assign vector_valid = (state == S_ACK2) && !inta_n;
    assign vector_out   = vector_valid ? {base_hi, ack_index} : '0;
    assign int_out      = int_q;
    assign irr_out      = irr;
    assign isr_out      = isr;
    assign imr_out      = imr;

endmodule
